// File: rtl/byte_packer.sv
// Packs a byte stream into big-endian 32-bit words for the padder, marking the
// final word of each message and emitting an empty terminator after aligned messages.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in,
  input  logic        in_ready,
  input  logic        in_last,
  input  logic        in_nobyte,
  output logic        in_busy,
  output logic [31:0] out,
  output logic        out_ready,
  output logic        is_last,
  output logic [1:0]  byte_num,
  input  logic        buffer_full
);

  logic [31:0] acc_p0;
  logic [1:0]  cnt_p0;
  logic        term_pending;

  logic [31:0] acc_nx;
  logic [1:0]  cnt_nx;
  logic        term_nx;
  logic        load;
  logic [31:0] ld_word;
  logic        ld_last;
  logic [1:0]  ld_bn;

  logic        beat;
  logic        consume;
  logic        can_load;
  logic        nobyte;
  logic [31:0] merged;
  logic [2:0]  cnt_inc;

  // Lane 0 is the most significant byte, so earlier bytes land higher in the word.
  function automatic logic [31:0] put_byte(input logic [31:0] a, input logic [7:0] b,
                                           input logic [1:0] lane);
    logic [31:0] r;
    r = a;
    case (lane)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  // A pending terminator blocks input so it always owns the next free output slot.
  assign in_busy = (out_ready && buffer_full) || term_pending;

  always_comb begin
    beat     = in_ready && !in_busy;
    consume  = out_ready && !buffer_full;
    can_load = !out_ready || consume;
    nobyte   = in_last && in_nobyte;
    merged   = put_byte(acc_p0, in, cnt_p0);
    cnt_inc  = {1'b0, cnt_p0} + 3'd1;

    acc_nx  = acc_p0;
    cnt_nx  = cnt_p0;
    term_nx = term_pending;
    load    = 1'b0;
    ld_word = 32'd0;
    ld_last = 1'b0;
    ld_bn   = 2'd0;

    if (term_pending) begin
      if (can_load) begin
        load    = 1'b1;
        ld_last = 1'b1;
        term_nx = 1'b0;
      end
    end else if (beat) begin
      if (nobyte) begin
        load    = 1'b1;
        ld_word = acc_p0;
        ld_last = 1'b1;
        ld_bn   = cnt_p0;
        acc_nx  = 32'd0;
        cnt_nx  = 2'd0;
      end else if (cnt_inc == 3'd4) begin
        // A full word never carries is_last; a last beat here defers to the terminator.
        load    = 1'b1;
        ld_word = merged;
        acc_nx  = 32'd0;
        cnt_nx  = 2'd0;
        term_nx = in_last;
      end else if (in_last) begin
        load    = 1'b1;
        ld_word = merged;
        ld_last = 1'b1;
        ld_bn   = cnt_inc[1:0];
        acc_nx  = 32'd0;
        cnt_nx  = 2'd0;
      end else begin
        acc_nx = merged;
        cnt_nx = cnt_inc[1:0];
      end
    end
  end

  // Stage p0 -> output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_p0       <= 32'd0;
      cnt_p0       <= 2'd0;
      term_pending <= 1'b0;
      out          <= 32'd0;
      is_last      <= 1'b0;
      byte_num     <= 2'd0;
      out_ready    <= 1'b0;
    end else begin
      acc_p0       <= acc_nx;
      cnt_p0       <= cnt_nx;
      term_pending <= term_nx;
      if (load) begin
        out       <= ld_word;
        is_last   <= ld_last;
        byte_num  <= ld_bn;
        out_ready <= 1'b1;
      end else if (consume) begin
        out_ready <= 1'b0;
      end
    end
  end

endmodule
